display_scheduler: RTL and testbench

Shares the 4-digit multiplexed 7-segment display between two value sources (req[0], e.g. the counter, and req[1], e.g. a status/overlay value) and sequences the digit scan. It generates the scan-advance strobe for the digit multiplexer, arbitrates ownership round-robin with a minimum hold time, inserts a blanked gap between owners, and applies per-source blinking. It sits between the sources and the BCD/digit-multiplexer path.

---
 rtl/display_pkg.sv | 18 +
 rtl/scan_prescaler.sv | 26 ++
 rtl/display_scheduler.sv | 144 ++++++++++++++
 tb/tb_display_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types for the display scheduler: arbiter state encoding and source indices.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int SRC0 = 0;
  localparam int SRC1 = 1;

  function automatic logic [1:0] src_onehot(input int src);
    return (src == SRC1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider producing a one-cycle scan strobe every SCAN_DIV clocks.
module scan_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(SCAN_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin owner arbitration of the shared 7-segment display with minimum hold,
// blanked hand-over gap and per-source blinking, plus the digit scan strobe.
module display_scheduler
  import display_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_TICKS  = 200,
  parameter int GAP_TICKS   = 2,
  parameter int BLINK_TICKS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] value0,
  input  logic [15:0] value1,
  input  logic [1:0]  blink,
  output logic [1:0]  gnt,
  output logic [15:0] value_out,
  output logic        blank,
  output logic        scan_tick
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_TICKS);
  localparam logic [GW-1:0] GAP_MAX    = GW'(GAP_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  state_t        state, state_nxt, arb_state;
  logic          rr, rr_nxt;
  logic [HW-1:0] hold, hold_nxt;
  logic [GW-1:0] gap, gap_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic          phase, phase_nxt;
  logic [1:0]    gnt_d;
  logic [15:0]   value_d;
  logic          blank_d;
  logic          owning;

  scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (scan_tick)
  );

  assign owning = (state == OWN0) || (state == OWN1);

  // Grant decision shared by IDLE and the end of GAP; rr breaks ties.
  always_comb begin
    unique case (req)
      2'b01:   arb_state = OWN0;
      2'b10:   arb_state = OWN1;
      2'b11:   arb_state = rr ? OWN1 : OWN0;
      default: arb_state = IDLE;
    endcase
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    unique case (state)
      IDLE: state_nxt = arb_state;
      OWN0: if (!req[SRC0] || (req[SRC1] && hold == HOLD_MAX)) begin
        state_nxt = GAP;
        rr_nxt    = 1'b1;
      end
      OWN1: if (!req[SRC1] || (req[SRC0] && hold == HOLD_MAX)) begin
        state_nxt = GAP;
        rr_nxt    = 1'b0;
      end
      GAP:  if (gap == GAP_MAX) state_nxt = arb_state;
      default: state_nxt = IDLE;
    endcase

    hold_nxt  = hold;
    gap_nxt   = gap;
    bcnt_nxt  = bcnt;
    phase_nxt = phase;
    if (state_nxt != state) begin
      hold_nxt  = '0;
      gap_nxt   = '0;
      bcnt_nxt  = '0;
      phase_nxt = 1'b0;
    end else if (scan_tick) begin
      if (owning) begin
        if (hold != HOLD_MAX) hold_nxt = hold + HW'(1);
        if (bcnt == BLINK_LAST) begin
          bcnt_nxt  = '0;
          phase_nxt = ~phase;
        end else begin
          bcnt_nxt = bcnt + BW'(1);
        end
      end
      if (state == GAP && gap != GAP_MAX) gap_nxt = gap + GW'(1);
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    gnt_d   = 2'b00;
    blank_d = 1'b1;
    value_d = value_out;
    unique case (state_nxt)
      OWN0: begin
        gnt_d   = src_onehot(SRC0);
        value_d = value0;
        blank_d = blink[SRC0] & phase_nxt;
      end
      OWN1: begin
        gnt_d   = src_onehot(SRC1);
        value_d = value1;
        blank_d = blink[SRC1] & phase_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      hold      <= '0;
      gap       <= '0;
      bcnt      <= '0;
      phase     <= 1'b0;
      gnt       <= 2'b00;
      value_out <= '0;
      blank     <= 1'b1;
    end else begin
      state     <= state_nxt;
      rr        <= rr_nxt;
      hold      <= hold_nxt;
      gap       <= gap_nxt;
      bcnt      <= bcnt_nxt;
      phase     <= phase_nxt;
      gnt       <= gnt_d;
      value_out <= value_d;
      blank     <= blank_d;
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Randomized scoreboard bench for display_scheduler against a tick-counting reference model.
module tb_display_scheduler;

  localparam int SD = 4;
  localparam int HT = 3;
  localparam int GT = 1;
  localparam int BT = 2;

  localparam int M_IDLE = 0;
  localparam int M_OWN  = 1;
  localparam int M_GAP  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  blink = 2'b00;
  logic [15:0] value0 = '0;
  logic [15:0] value1 = '0;
  logic [1:0]  gnt;
  logic [15:0] value_out;
  logic        blank;
  logic        scan_tick;

  always #5 clk = ~clk;

  display_scheduler #(
    .SCAN_DIV    (SD),
    .HOLD_TICKS  (HT),
    .GAP_TICKS   (GT),
    .BLINK_TICKS (BT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .value0    (value0),
    .value1    (value1),
    .blink     (blink),
    .gnt       (gnt),
    .value_out (value_out),
    .blank     (blank),
    .scan_tick (scan_tick)
  );

  typedef struct packed {
    logic [1:0]  gnt;
    logic [15:0] val;
    logic        blank;
    logic        tick;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner plus tick counts since grant / since gap start.
  int          m_mode, m_owner, m_ticks, m_gap, m_rr, m_k;
  logic [15:0] m_val;

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_owner = 0;
    m_ticks = 0;
    m_gap   = 0;
    m_rr    = 0;
    m_k     = 0;
    m_val   = '0;
  endtask

  task automatic model_grant(input logic [1:0] r);
    if (r == 2'b00) begin
      m_mode = M_IDLE;
    end else begin
      m_owner = (r == 2'b01) ? 0 : (r == 2'b10) ? 1 : m_rr;
      m_mode  = M_OWN;
      m_ticks = 0;
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit   tick_in;
    int   other;
    tick_in = (m_k >= 1) && (m_k % SD == 0);
    m_k++;
    case (m_mode)
      M_OWN: begin
        other = 1 - m_owner;
        if (!req[m_owner] || (req[other] && m_ticks >= HT)) begin
          m_mode = M_GAP;
          m_gap  = 0;
          m_rr   = other;
        end else if (tick_in) begin
          m_ticks++;
        end
      end
      M_GAP: begin
        if (m_gap >= GT) model_grant(req);
        else if (tick_in) m_gap++;
      end
      default: model_grant(req);
    endcase
    if (m_mode == M_OWN) begin
      m_val   = (m_owner == 1) ? value1 : value0;
      e.gnt   = (m_owner == 1) ? 2'b10 : 2'b01;
      e.blank = blink[m_owner] & (((m_ticks / BT) % 2) == 1);
    end else begin
      e.gnt   = 2'b00;
      e.blank = 1'b1;
    end
    e.val  = m_val;
    e.tick = (m_k % SD == 0);
    sb.push_back(e);
  endtask

  // Called just after an edge with new inputs already driven.
  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #2;
    end
  endtask

  task automatic reset_now(input string tag);
    #1;
    rst = 1'b1;
    #1;
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_blank"}, 32'(blank), 32'd1);
    check({tag, "_value"}, 32'(value_out), 32'd0);
    check({tag, "_tick"}, 32'(scan_tick), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compares every registered output sample with the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("gnt", 32'(gnt), 32'(e.gnt));
        check("value_out", 32'(value_out), 32'(e.val));
        check("blank", 32'(blank), 32'(e.blank));
        check("scan_tick", 32'(scan_tick), 32'(e.tick));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Idle with scan strobe only.
    cycle(40);

    // Single requester, then live value update, then release.
    req = 2'b01; value0 = 16'd1234;
    cycle(5);
    value0 = 16'd42;
    cycle(3);
    req = 2'b00;
    cycle(12);

    // Both requesting: round-robin with hold and gap.
    req = 2'b11; value0 = 16'h1111; value1 = 16'hBEEF;
    cycle(60);

    // Drop req[1] early in OWN1 while source 0 waits.
    for (int i = 0; i < 200 && !(m_mode == M_OWN && m_owner == 1 && m_ticks == 1); i++) cycle();
    check("reach_own1_hold1", 32'(m_mode == M_OWN && m_owner == 1 && m_ticks == 1), 32'd1);
    req = 2'b01;
    cycle(20);
    req = 2'b00;
    cycle(8);

    // Blinking owner, then regrant restarts the phase.
    blink = 2'b01; req = 2'b01;
    cycle(30);
    req = 2'b00;
    cycle(8);
    req = 2'b01;
    cycle(15);
    blink = 2'b00; req = 2'b00;
    cycle(8);

    // Asynchronous reset during GAP and during OWN1.
    req = 2'b11;
    for (int i = 0; i < 200 && m_mode != M_GAP; i++) cycle();
    check("reach_gap", 32'(m_mode), 32'(M_GAP));
    reset_now("rst_gap");
    req = 2'b11;
    for (int i = 0; i < 200 && !(m_mode == M_OWN && m_owner == 1); i++) cycle();
    check("reach_own1", 32'(m_mode == M_OWN && m_owner == 1), 32'd1);
    reset_now("rst_own1");
    req = 2'b11;
    cycle(10);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) blink = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) value0 = 16'($urandom);
      if ($urandom_range(0, 1) == 0) value1 = 16'($urandom);
      if ($urandom_range(0, 499) == 0) reset_now("rst_rand");
      cycle();
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #5;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
